// File: rtl/qam_mapper_controller.sv
// 16-QAM transmit mapper: pops bytes from a show-ahead FIFO, emits two Gray-mapped I/Q pairs per byte.
// Optional SYM_COUNT_EN adds a saturating per-frame count of pushed symbols on sym_count.
module qam_mapper_controller #(
  parameter int DATA_W  = 8,
  parameter int LEVEL_W = 3
) (
  input  logic                      dclk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      start,
  input  logic                      rdempty,
  input  logic [DATA_W-1:0]         din,
  output logic                      read_enable,
  input  logic                      wfull,
  output logic                      write_enable,
  output logic signed [LEVEL_W-1:0] i_out,
  output logic signed [LEVEL_W-1:0] q_out,
  output logic                      available,
  output logic                      complete,
  output logic [1:0]                state,
  output logic [1:0]                nextstate
`ifdef SYM_COUNT_EN
  ,
  output logic [15:0]               sym_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    MAP  = 2'b10,
    DONE = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              sym_cnt_q, sym_cnt_d;
  logic              rd, wr;

  function automatic logic signed [LEVEL_W-1:0] gray(input logic [1:0] f);
    case (f)
      2'b00:   gray = LEVEL_W'(-3);
      2'b01:   gray = LEVEL_W'(-1);
      2'b11:   gray = LEVEL_W'(1);
      default: gray = LEVEL_W'(3);
    endcase
  endfunction

  // enable gates every transition, so a frozen FSM still reports its held state as nextstate
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    sym_cnt_d = sym_cnt_q;
    rd        = 1'b0;
    wr        = 1'b0;
    case (state_q)
      IDLE: if (enable && start) state_d = LOAD;
      LOAD: if (enable) begin
        if (!rdempty) begin
          rd        = 1'b1;
          shreg_d   = din;
          sym_cnt_d = 1'b0;
          state_d   = MAP;
        end else begin
          state_d = DONE;
        end
      end
      MAP: if (enable && !wfull) begin
        wr = 1'b1;
        if (!sym_cnt_q) begin
          shreg_d   = {shreg_q[DATA_W-5:0], 4'b0000};
          sym_cnt_d = 1'b1;
        end else begin
          state_d = LOAD;
        end
      end
      DONE: if (enable && !start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      sym_cnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      sym_cnt_q <= sym_cnt_d;
    end
  end

  assign read_enable  = rd;
  assign write_enable = wr;
  assign available    = (state_q == IDLE);
  assign complete     = (state_q == DONE);
  assign state        = state_q;
  assign nextstate    = state_d;
  assign i_out        = (state_q == MAP) ? gray(shreg_q[DATA_W-1:DATA_W-2]) : '0;
  assign q_out        = (state_q == MAP) ? gray(shreg_q[DATA_W-3:DATA_W-4]) : '0;

`ifdef SYM_COUNT_EN
  logic [15:0] sym_count_q;

  always_ff @(posedge dclk or posedge reset) begin
    if (reset)
      sym_count_q <= '0;
    else if (state_q == IDLE && state_d == LOAD)
      sym_count_q <= '0;
    else if (wr && sym_count_q != 16'hFFFF)
      sym_count_q <= sym_count_q + 16'd1;
  end

  assign sym_count = sym_count_q;
`endif

endmodule

// File: tb/tb_qam_mapper_controller.sv
// Bench for qam_mapper_controller: source FIFO model, I/Q scoreboard, vector table and corner sequences.
module tb_qam_mapper_controller;

  logic       dclk, reset, enable, start, rdempty, wfull;
  logic [7:0] din;
  logic       read_enable, write_enable, available, complete;
  logic [2:0] i_out, q_out;
  logic [1:0] state, nextstate;
`ifdef SYM_COUNT_EN
  logic [15:0] sym_count;
`endif

  qam_mapper_controller #(.DATA_W(8), .LEVEL_W(3)) dut (
    .dclk(dclk), .reset(reset), .enable(enable), .start(start),
    .rdempty(rdempty), .din(din), .read_enable(read_enable),
    .wfull(wfull), .write_enable(write_enable),
    .i_out(i_out), .q_out(q_out), .available(available), .complete(complete),
    .state(state), .nextstate(nextstate)
`ifdef SYM_COUNT_EN
    , .sym_count(sym_count)
`endif
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  typedef struct {
    logic [7:0] d;
    logic [2:0] i0, q0, i1, q1;
  } vec_t;

  logic [7:0] src[$];
  logic [5:0] sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [2:0] lvl(input logic [1:0] f);
    case (f)
      2'b00:   lvl = 3'b101;
      2'b01:   lvl = 3'b111;
      2'b11:   lvl = 3'b001;
      default: lvl = 3'b011;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    rdempty = (src.size() == 0);
    din     = (src.size() != 0) ? src[0] : 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    src.push_back(b);
    sb.push_back({lvl(b[7:6]), lvl(b[5:4])});
    sb.push_back({lvl(b[3:2]), lvl(b[1:0])});
    refresh();
  endtask

  // Strobes are sampled mid-low-phase; the FIFO pop is applied just after the edge that consumed it.
  task automatic tick();
    logic re_s;
    logic [5:0] e;
    #1;
    re_s = read_enable;
    if (write_enable) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow: unexpected push iq=%b_%b", i_out, q_out);
      end else begin
        e = sb.pop_front();
        chk("push_iq", {26'd0, i_out, q_out}, {26'd0, e});
      end
    end
    @(posedge dclk);
    #1;
    if (re_s && src.size() != 0) void'(src.pop_front());
    refresh();
    @(negedge dclk);
  endtask

  task automatic finish_frame(input int limit);
    int n = 0;
    while (complete !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk("frame_timeout", {31'd0, complete}, 32'd1);
    start = 1'b0;
    tick();
    chk("back_to_idle", {30'd0, state}, 32'd0);
    chk("sb_drained", sb.size(), 0);
    chk("src_drained", src.size(), 0);
  endtask

  task automatic run_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_frame(200);
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{8'hB4, 3'b011, 3'b001, 3'b111, 3'b101};
    vecs[1] = '{8'h0F, 3'b101, 3'b101, 3'b001, 3'b001};
    vecs[2] = '{8'h5A, 3'b111, 3'b111, 3'b011, 3'b011};
    vecs[3] = '{8'h9C, 3'b011, 3'b111, 3'b001, 3'b101};
    vecs[4] = '{8'h36, 3'b101, 3'b001, 3'b111, 3'b011};
    vecs[5] = '{8'hE1, 3'b001, 3'b011, 3'b101, 3'b111};

    reset = 1'b1; enable = 1'b1; start = 1'b0; wfull = 1'b0;
    refresh();
    @(negedge dclk);
    tick();
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_next", {30'd0, nextstate}, 32'd0);
    chk("rst_flags", {28'd0, available, complete, read_enable, write_enable}, 32'b1000);
    chk("rst_iq", {26'd0, i_out, q_out}, 32'd0);
    reset = 1'b0;
    tick();

    // empty FIFO: LOAD -> DONE, hold while start high, IDLE on release
    start = 1'b1;
    tick();
    chk("empty_load", {30'd0, state}, 32'd1);
    chk("empty_nopop", {31'd0, read_enable}, 32'd0);
    chk("empty_next", {30'd0, nextstate}, 32'd3);
    tick();
    chk("empty_done", {30'd0, state, complete}, 32'b111);
    tick();
    chk("done_hold", {30'd0, state}, 32'd3);
    start = 1'b0;
    tick();
    chk("done_idle", {31'd0, available}, 32'd1);

    // exact cycle sequence for B4
    push_byte(8'hB4);
    start = 1'b1;
    tick();
    chk("b4_load_pop", {29'd0, state, read_enable}, 32'b011);
    start = 1'b0;
    tick();
    chk("b4_sym0", {23'd0, state, write_enable, i_out, q_out}, {23'd0, 2'b10, 1'b1, 3'b011, 3'b001});
    tick();
    chk("b4_sym1", {23'd0, state, write_enable, i_out, q_out}, {23'd0, 2'b10, 1'b1, 3'b111, 3'b101});
    tick();
    chk("b4_reload_empty", {29'd0, state, read_enable}, 32'b010);
    tick();
    chk("b4_done", {30'd0, state}, 32'd3);
    tick();
    chk("b4_idle", {30'd0, state}, 32'd0);
    chk("b4_sb", sb.size(), 0);

    // vector table: one single-byte frame per record
    for (int v = 0; v < 6; v++) begin
      src.push_back(vecs[v].d);
      sb.push_back({vecs[v].i0, vecs[v].q0});
      sb.push_back({vecs[v].i1, vecs[v].q1});
      refresh();
      run_frame();
    end

    // back-pressure on 0F for 5 cycles in MAP
    push_byte(8'h0F);
    start = 1'b1;
    tick();
    start = 1'b0;
    wfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold", {23'd0, state, write_enable, i_out, q_out}, {23'd0, 2'b10, 1'b0, 3'b101, 3'b101});
    end
    wfull = 1'b0;
    finish_frame(50);

    // enable dropped: once in LOAD with data, then 4 cycles in MAP
    push_byte(8'h5A);
    push_byte(8'h9C);
    start = 1'b1;
    tick();
    start = 1'b0;
    enable = 1'b0;
    #1;
    chk("en_load_nopop", {29'd0, state, read_enable}, 32'b010);
    tick();
    chk("en_load_hold", {30'd0, state}, 32'd1);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("en_map_freeze", {27'd0, state, nextstate, write_enable}, {27'd0, 2'b10, 2'b10, 1'b0});
    end
    enable = 1'b1;
    finish_frame(50);

    // async reset on the second symbol of a 3-byte frame
    push_byte(8'h36);
    push_byte(8'hE1);
    push_byte(8'h9C);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_state", {30'd0, state}, 32'd0);
    chk("arst_flags", {28'd0, available, complete, read_enable, write_enable}, 32'b1000);
    sb.delete();
    sb.push_back({lvl(2'b11), lvl(2'b10)});
    sb.push_back({lvl(2'b00), lvl(2'b01)});
    sb.push_back({lvl(2'b10), lvl(2'b01)});
    sb.push_back({lvl(2'b11), lvl(2'b00)});
    @(negedge dclk);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_quiet", {30'd0, read_enable, write_enable}, 32'd0);
    end
    chk("post_rst_src", src.size(), 2);
    run_frame();

`ifdef SYM_COUNT_EN
    for (int k = 0; k < 4; k++) push_byte(vecs[k].d);
    start = 1'b1;
    tick();
    start = 1'b0;
    begin
      int n = 0;
      while (complete !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
    end
    chk("symcnt_done", {16'd0, sym_count}, 32'd8);
    tick();
    chk("symcnt_idle", {16'd0, sym_count}, 32'd8);
    start = 1'b1;
    tick();
    chk("symcnt_clear", {16'd0, sym_count}, 32'd0);
    start = 1'b0;
    finish_frame(20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time %0t", $time);
    $fatal(1);
  end

endmodule
